gate_access_ctrl: RTL and testbench



---
 rtl/gate_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/gate_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_gate_access_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_pkg
// Description : Shared constants, request-FSM state codes and a span helper
//               for the player-side gate access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_pkg;

  localparam int COORD_W = 10;
  localparam int FRAME_W = 3;
  localparam logic [FRAME_W-1:0] FRAME_MAX = 3'd7;

  // Comparisons carry one extra bit so box edges plus margins never wrap.
  localparam int CMP_W = COORD_W + 1;
  typedef logic [CMP_W-1:0] cmp_t;

  // Request FSM state codes.
  typedef logic [1:0] gate_state_t;
  localparam gate_state_t IDLE   = 2'd0;
  localparam gate_state_t REQ    = 2'd1;
  localparam gate_state_t OPEN   = 2'd2;
  localparam gate_state_t DENIED = 2'd3;

  // Half-open interval test: lo <= v < hi.
  function automatic logic in_span(input cmp_t v, input cmp_t lo, input cmp_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, stable-sample debouncer and rising
//               edge detector for a raw push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int c_cnt_w = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_level;
  logic               r_rise;
  logic [c_cnt_w-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DEBOUNCE consecutive differing samples;
  // the rise pulse is emitted together with the level update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_rise  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + c_cnt_one;
      end
    end
  end

  assign btn_level = r_level;
  assign btn_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/gate_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_access_ctrl
// Description : Turns player position and the open button into the gate's
//               spotfilled/opengate/neargate requests, runs the request/grant
//               handshake and drives the door animation frame.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_access_ctrl
  import gate_pkg::*;
#(
  parameter int SPOT_X      = 100,
  parameter int SPOT_Y      = 300,
  parameter int SPOT_SIZE   = 32,
  parameter int GATE_X      = 500,
  parameter int GATE_Y      = 200,
  parameter int GATE_SIZE   = 64,
  parameter int NEAR_MARGIN = 16,
  parameter int DEBOUNCE    = 250000,
  parameter int HOLD_CYCLES = 1000000,
  parameter int REQ_TIMEOUT = 5000000,
  parameter int DENY_CYCLES = 2500000,
  parameter int FRAME_TICKS = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic               btn_open,
  input  logic               level_clear,
  input  logic               gatestatus,
  output logic               spotfilled,
  output logic               opengate,
  output logic               neargate,
  output logic               denied,
  output logic [FRAME_W-1:0] gate_frame
);

  // Box edges; the near region's low edge clamps at 0 instead of wrapping.
  localparam cmp_t c_spot_x_lo = cmp_t'(SPOT_X);
  localparam cmp_t c_spot_x_hi = cmp_t'(SPOT_X + SPOT_SIZE);
  localparam cmp_t c_spot_y_lo = cmp_t'(SPOT_Y);
  localparam cmp_t c_spot_y_hi = cmp_t'(SPOT_Y + SPOT_SIZE);
  localparam cmp_t c_near_x_lo = cmp_t'((GATE_X >= NEAR_MARGIN) ? (GATE_X - NEAR_MARGIN) : 0);
  localparam cmp_t c_near_x_hi = cmp_t'(GATE_X + GATE_SIZE + NEAR_MARGIN);
  localparam cmp_t c_near_y_lo = cmp_t'((GATE_Y >= NEAR_MARGIN) ? (GATE_Y - NEAR_MARGIN) : 0);
  localparam cmp_t c_near_y_hi = cmp_t'(GATE_Y + GATE_SIZE + NEAR_MARGIN);

  localparam int c_hold_w  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int c_tmax    = (REQ_TIMEOUT > DENY_CYCLES) ? REQ_TIMEOUT : DENY_CYCLES;
  localparam int c_timer_w = (c_tmax > 1) ? $clog2(c_tmax) : 1;
  localparam int c_pre_w   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  localparam logic [c_hold_w-1:0]  c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
  localparam logic [c_hold_w-1:0]  c_hold_one  = c_hold_w'(1);
  localparam logic [c_timer_w-1:0] c_req_last  = c_timer_w'(REQ_TIMEOUT - 1);
  localparam logic [c_timer_w-1:0] c_deny_last = c_timer_w'(DENY_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_timer_one = c_timer_w'(1);
  localparam logic [c_pre_w-1:0]   c_pre_last  = c_pre_w'(FRAME_TICKS - 1);
  localparam logic [c_pre_w-1:0]   c_pre_one   = c_pre_w'(1);

  cmp_t                w_px;
  cmp_t                w_py;
  logic                w_in_spot;
  logic                w_in_near;
  logic                w_btn_level;
  logic                w_btn_rise;
  logic                w_btn_evt;
  logic                w_frame_tick;
  gate_state_t         w_state_nxt;

  logic                r_neargate;
  logic                r_spotfilled;
  logic [c_hold_w-1:0] r_hold_cnt;
  gate_state_t         r_state;
  logic [c_timer_w-1:0] r_timer;
  logic [c_pre_w-1:0]  r_pre;
  logic [FRAME_W-1:0]  r_frame;

  assign w_px      = {1'b0, player_x};
  assign w_py      = {1'b0, player_y};
  assign w_in_spot = in_span(w_px, c_spot_x_lo, c_spot_x_hi) && in_span(w_py, c_spot_y_lo, c_spot_y_hi);
  assign w_in_near = in_span(w_px, c_near_x_lo, c_near_x_hi) && in_span(w_py, c_near_y_lo, c_near_y_hi);

  btn_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_btn_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_open),
    .btn_level (w_btn_level),
    .btn_rise  (w_btn_rise)
  );

  // The rise pulse always coincides with a high debounced level.
  assign w_btn_evt = w_btn_rise & w_btn_level;

  // Register the near-region decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_neargate <= 1'b0;
    else     r_neargate <= w_in_near;
  end

  // Count consecutive on-spot cycles and latch spotfilled; level_clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt   <= '0;
      r_spotfilled <= 1'b0;
    end else if (level_clear) begin
      r_hold_cnt   <= '0;
      r_spotfilled <= 1'b0;
    end else if (!w_in_spot) begin
      r_hold_cnt <= '0;
    end else if (!r_spotfilled) begin
      if (r_hold_cnt == c_hold_last) begin
        r_hold_cnt   <= '0;
        r_spotfilled <= 1'b1;
      end else begin
        r_hold_cnt <= r_hold_cnt + c_hold_one;
      end
    end
  end

  // Next-state decode; a grant arriving on the timeout cycle still opens.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_btn_evt && r_neargate) w_state_nxt = REQ;
      REQ: begin
        if (!r_neargate)                w_state_nxt = IDLE;
        else if (gatestatus)            w_state_nxt = OPEN;
        else if (r_timer == c_req_last) w_state_nxt = DENIED;
      end
      OPEN:    if (!r_neargate || !gatestatus) w_state_nxt = IDLE;
      DENIED:  if (r_timer == c_deny_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus a shared dwell timer restarted on every transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_timer <= '0;
      else if (r_state == REQ || r_state == DENIED)
        r_timer <= r_timer + c_timer_one;
      else
        r_timer <= '0;
    end
  end

  assign w_frame_tick = (r_pre == c_pre_last);

  // Free-running animation prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_pre <= '0;
    else if (w_frame_tick) r_pre <= '0;
    else                   r_pre <= r_pre + c_pre_one;
  end

  // Step the door frame toward open or closed, saturating at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= '0;
    end else if (w_frame_tick) begin
      if (gatestatus && r_frame != FRAME_MAX)
        r_frame <= r_frame + 3'd1;
      else if (!gatestatus && r_frame != '0)
        r_frame <= r_frame - 3'd1;
    end
  end

  assign spotfilled = r_spotfilled;
  assign neargate   = r_neargate;
  assign opengate   = (r_state == REQ) || (r_state == OPEN);
  assign denied     = (r_state == DENIED);
  assign gate_frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_gate_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_access_ctrl
// Description : Directed self-checking bench for gate_access_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       btn_open;
  logic       level_clear;
  logic       gatestatus;
  logic       spotfilled;
  logic       opengate;
  logic       neargate;
  logic       denied;
  logic [2:0] gate_frame;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wait;

  gate_access_ctrl #(
    .DEBOUNCE    (4),
    .HOLD_CYCLES (8),
    .REQ_TIMEOUT (16),
    .DENY_CYCLES (6),
    .FRAME_TICKS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .player_x    (player_x),
    .player_y    (player_y),
    .btn_open    (btn_open),
    .level_clear (level_clear),
    .gatestatus  (gatestatus),
    .spotfilled  (spotfilled),
    .opengate    (opengate),
    .neargate    (neargate),
    .denied      (denied),
    .gate_frame  (gate_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, leaving time 1 unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic place(input int x, input int y);
    player_x = 10'(x);
    player_y = 10'(y);
  endtask

  // Step until gate_frame equals v or the bound expires; n is edges taken.
  task automatic wait_frame(input logic [2:0] v, input int bound, output int n);
    n = 0;
    while (gate_frame !== v && n < bound) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; btn_open = 1'b0; level_clear = 1'b0; gatestatus = 1'b0;
    place(0, 0);
    step(2);
    chk("rst_spotfilled", spotfilled, 0);
    chk("rst_opengate",   opengate,   0);
    chk("rst_neargate",   neargate,   0);
    chk("rst_denied",     denied,     0);
    chk("rst_frame",      gate_frame, 0);
    rst = 1'b0;
    step(1);

    // Spot hold: 7 cycles not enough, 8 sets and latches.
    place(110, 310);
    step(7);
    chk("spot_7cyc", spotfilled, 0);
    step(1);
    chk("spot_8cyc", spotfilled, 1);
    place(0, 0);
    step(3);
    chk("spot_latched", spotfilled, 1);
    level_clear = 1'b1; step(1); level_clear = 1'b0;
    chk("spot_cleared", spotfilled, 0);
    place(110, 310);
    step(7);
    place(0, 0);
    step(2);
    chk("spot_short", spotfilled, 0);

    // Near region [484,580) x [184,280).
    place(485, 200); step(1); chk("near_485", neargate, 1);
    place(483, 200); step(1); chk("near_483", neargate, 0);
    place(484, 200); step(1); chk("near_484", neargate, 1);
    place(580, 220); step(1); chk("near_580", neargate, 0);
    place(579, 263); step(1); chk("near_579", neargate, 1);
    place(520, 280); step(1); chk("near_y280", neargate, 0);

    // Button debounce and grant.
    place(520, 220);
    step(2);
    btn_open = 1'b1; step(3); btn_open = 1'b0;
    step(8);
    chk("short_press", opengate, 0);
    btn_open = 1'b1;
    step(6);
    chk("req_not_yet", opengate, 0);
    step(1);
    chk("req_rise", opengate, 1);
    gatestatus = 1'b1;
    wait_frame(3'd7, 20, n_wait);
    chk("frame_reach7", gate_frame, 7);
    chk("frame_lat", (n_wait == 13 || n_wait == 14), 1);
    step(4);
    chk("frame_hold7", gate_frame, 7);
    chk("open_held", opengate, 1);
    gatestatus = 1'b0;
    step(1);
    chk("open_close", opengate, 0);
    btn_open = 1'b0;
    wait_frame(3'd0, 20, n_wait);
    chk("frame_down0", gate_frame, 0);
    step(4);

    // Timeout to DENIED, press during DENIED ignored.
    btn_open = 1'b1;
    step(7);
    chk("t4_req", opengate, 1);
    btn_open = 1'b0;
    step(12);
    btn_open = 1'b1;
    step(3);
    chk("t4_pre_denied", denied, 0);
    chk("t4_pre_open", opengate, 1);
    step(1);
    chk("t4_denied", denied, 1);
    chk("t4_req_drop", opengate, 0);
    step(5);
    chk("t4_denied_6", denied, 1);
    step(1);
    chk("t4_idle", denied, 0);
    step(2);
    chk("t4_no_req", opengate, 0);
    btn_open = 1'b0;
    step(8);

    // Grant on the timeout cycle, then walk away.
    btn_open = 1'b1;
    step(7);
    chk("t5_req", opengate, 1);
    btn_open = 1'b0;
    step(15);
    gatestatus = 1'b1;
    step(1);
    chk("t5_open", opengate, 1);
    chk("t5_not_denied", denied, 0);
    step(2);
    chk("t5_still_ok", denied, 0);
    place(0, 0);
    step(1);
    chk("t5_near_drop", neargate, 0);
    chk("t5_open_hold", opengate, 1);
    step(1);
    chk("t5_open_fall", opengate, 0);

    // Reset mid-OPEN at frame 5.
    gatestatus = 1'b0;
    wait_frame(3'd0, 20, n_wait);
    place(110, 310);
    step(8);
    chk("t6_spot", spotfilled, 1);
    place(520, 220);
    step(2);
    btn_open = 1'b1;
    step(7);
    chk("t6_req", opengate, 1);
    btn_open = 1'b0;
    gatestatus = 1'b1;
    wait_frame(3'd5, 20, n_wait);
    chk("t6_frame5", gate_frame, 5);
    chk("t6_open", opengate, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_spot",   spotfilled, 0);
    chk("t6_rst_open",   opengate,   0);
    chk("t6_rst_near",   neargate,   0);
    chk("t6_rst_denied", denied,     0);
    chk("t6_rst_frame",  gate_frame, 0);
    step(2);
    place(0, 0);
    gatestatus = 1'b0;
    rst = 1'b0;
    btn_open = 1'b1;
    step(10);
    chk("t6_far_press", opengate, 0);
    chk("t6_far_denied", denied, 0);
    btn_open = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
